// File: rtl/hazard_controller.sv
// Pipeline hazard controller: execute/decode operand forwarding, load-use and
// branch-compare stall detection, and multiply/divide occupancy tracking.
module hazard_controller #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  input  logic       md_start_e,
  input  logic       md_is_div_e,
  input  logic       md_use_d,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_e,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       forward_a_d,
  output logic       forward_b_d,
  output logic       md_busy,
  output logic       md_done
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_W-1:0] FWD_M  = 2'b10;
  localparam logic [FWD_W-1:0] FWD_W_ = 2'b01;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic any_stall;

  // A producer matches a consumer only if it writes a nonzero register.
  function automatic logic hit(input logic we, input logic [REG_W-1:0] dst,
                               input logic [REG_W-1:0] src);
    return we && (dst != '0) && (dst == src);
  endfunction

  // Execute-stage operand select; M result is newer than W so it wins.
  always_comb begin
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    if (!rst) begin
      if (hit(reg_write_m, write_reg_m, rs_e))      forward_a_e = FWD_M;
      else if (hit(reg_write_w, write_reg_w, rs_e)) forward_a_e = FWD_W_;
      if (hit(reg_write_m, write_reg_m, rt_e))      forward_b_e = FWD_M;
      else if (hit(reg_write_w, write_reg_w, rt_e)) forward_b_e = FWD_W_;
    end
  end

  // Decode branch-compare operands can only be bypassed from M.
  always_comb begin
    forward_a_d = 1'b0;
    forward_b_d = 1'b0;
    if (!rst) begin
      forward_a_d = hit(reg_write_m, write_reg_m, rs_d);
      forward_b_d = hit(reg_write_m, write_reg_m, rt_d);
    end
  end

  // Stall sources are OR-ed, so coincident hazards yield one stall.
  always_comb begin
    lw_stall  = hit(mem_to_reg_e, write_reg_e, rs_d) ||
                hit(mem_to_reg_e, write_reg_e, rt_d);
    br_stall  = branch_d &&
                (hit(reg_write_e,  write_reg_e, rs_d) ||
                 hit(reg_write_e,  write_reg_e, rt_d) ||
                 hit(mem_to_reg_m, write_reg_m, rs_d) ||
                 hit(mem_to_reg_m, write_reg_m, rt_d));
    md_stall  = md_use_d && (md_busy || md_start_e);
    any_stall = !rst && (lw_stall || br_stall || md_stall);
    stall_f   = any_stall;
    stall_d   = any_stall;
    flush_e   = any_stall;
  end

  // Latency to load depends on the operation being started.
  always_comb begin
    load_val = md_is_div_e ? DIV_LOAD : MUL_LOAD;
  end

  // Multiply/divide occupancy FSM; runs regardless of pipeline stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          md_done <= 1'b0;
          if (md_start_e) begin
            state   <= BUSY;
            cnt     <= load_val;
            md_busy <= 1'b1;
            md_done <= (load_val == CNT_W'(1));
          end
        end
        BUSY: begin
          // A new start while busy is dropped; the count is not reloaded.
          if (cnt == CNT_W'(1)) begin
            state   <= IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
          end else begin
            cnt     <= cnt - CNT_W'(1);
            md_busy <= 1'b1;
            md_done <= (cnt == CNT_W'(2));
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          md_busy <= 1'b0;
          md_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, stalls, md FSM timing, reset.
module tb_hazard_controller;

  logic       clk;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, md_start_e, md_is_div_e, md_use_d;
  logic       stall_f, stall_d, flush_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic       forward_a_d, forward_b_d;
  logic       md_busy, md_done;

  int checks;
  int errors;

  hazard_controller #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .branch_d(branch_d), .md_start_e(md_start_e), .md_is_div_e(md_is_div_e),
    .md_use_d(md_use_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .md_busy(md_busy), .md_done(md_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    write_reg_e = '0; write_reg_m = '0; write_reg_w = '0;
    reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    mem_to_reg_e = 1'b0; mem_to_reg_m = 1'b0;
    branch_d = 1'b0; md_start_e = 1'b0; md_is_div_e = 1'b0; md_use_d = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    write_reg_m = 5'd5; reg_write_m = 1'b1; rs_e = 5'd5; rt_e = 5'd5; rs_d = 5'd5;
    mem_to_reg_e = 1'b1; write_reg_e = 5'd5;
    md_start_e = 1'b1; md_use_d = 1'b1;
    #1;
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin
      errors++; $display("FAIL reset_stall got %b exp 000", {stall_f, stall_d, flush_e});
    end
    checks++;
    if ({forward_a_e, forward_b_e, forward_a_d, forward_b_d} !== 6'b0) begin
      errors++; $display("FAIL reset_fwd got %b exp 000000",
                         {forward_a_e, forward_b_e, forward_a_d, forward_b_d});
    end
    tick();
    tick();
    checks++;
    if ({md_busy, md_done} !== 2'b00) begin
      errors++; $display("FAIL reset_md got %b exp 00", {md_busy, md_done});
    end
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (md_busy !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored got %b exp 0", md_busy);
    end
    tick();
  endtask

  task automatic test_forward();
    clear_inputs();
    write_reg_m = 5'd5; reg_write_m = 1'b1; write_reg_w = 5'd5; reg_write_w = 1'b1;
    rs_e = 5'd5;
    #1;
    checks++;
    if (forward_a_e !== 2'b10) begin
      errors++; $display("FAIL fwd_a_m_prio got %b exp 10", forward_a_e);
    end
    reg_write_m = 1'b0;
    #1;
    checks++;
    if (forward_a_e !== 2'b01) begin
      errors++; $display("FAIL fwd_a_w got %b exp 01", forward_a_e);
    end
    reg_write_m = 1'b1; write_reg_m = '0; write_reg_w = '0; rs_e = '0;
    #1;
    checks++;
    if (forward_a_e !== 2'b00) begin
      errors++; $display("FAIL fwd_a_r0 got %b exp 00", forward_a_e);
    end
    write_reg_m = 5'd7; write_reg_w = 5'd9; rt_e = 5'd9; rs_e = 5'd7;
    #1;
    checks++;
    if ({forward_a_e, forward_b_e} !== 4'b1001) begin
      errors++; $display("FAIL fwd_ab_split got %b exp 1001", {forward_a_e, forward_b_e});
    end
    rt_e = 5'd7;
    #1;
    checks++;
    if (forward_b_e !== 2'b10) begin
      errors++; $display("FAIL fwd_b_m got %b exp 10", forward_b_e);
    end
    tick();
  endtask

  task automatic test_lw_stall();
    clear_inputs();
    mem_to_reg_e = 1'b1; write_reg_e = 5'd8; rt_d = 5'd8;
    #1;
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b111) begin
      errors++; $display("FAIL lw_stall_rt got %b exp 111", {stall_f, stall_d, flush_e});
    end
    tick();
    mem_to_reg_e = 1'b0; write_reg_e = '0;
    #1;
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin
      errors++; $display("FAIL lw_stall_release got %b exp 000", {stall_f, stall_d, flush_e});
    end
    mem_to_reg_e = 1'b1; write_reg_e = '0; rt_d = '0; rs_d = '0;
    #1;
    checks++;
    if (stall_f !== 1'b0) begin
      errors++; $display("FAIL lw_stall_r0 got %b exp 0", stall_f);
    end
    write_reg_e = 5'd12; rs_d = 5'd12; rt_d = 5'd1;
    #1;
    checks++;
    if (stall_d !== 1'b1) begin
      errors++; $display("FAIL lw_stall_rs got %b exp 1", stall_d);
    end
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    branch_d = 1'b1; rs_d = 5'd3; reg_write_e = 1'b1; write_reg_e = 5'd3;
    #1;
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b111) begin
      errors++; $display("FAIL br_stall_e got %b exp 111", {stall_f, stall_d, flush_e});
    end
    tick();
    reg_write_e = 1'b0; write_reg_e = '0;
    write_reg_m = 5'd3; reg_write_m = 1'b1; mem_to_reg_m = 1'b0;
    #1;
    checks++;
    if ({stall_f, forward_a_d, forward_b_d} !== 3'b010) begin
      errors++; $display("FAIL br_fwd_m got %b exp 010", {stall_f, forward_a_d, forward_b_d});
    end
    mem_to_reg_m = 1'b1;
    #1;
    checks++;
    if (stall_f !== 1'b1) begin
      errors++; $display("FAIL br_stall_load_m got %b exp 1", stall_f);
    end
    branch_d = 1'b0; mem_to_reg_m = 1'b0; reg_write_e = 1'b1; write_reg_e = 5'd3;
    #1;
    checks++;
    if (stall_f !== 1'b0) begin
      errors++; $display("FAIL nobr_no_stall got %b exp 0", stall_f);
    end
    tick();
  endtask

  task automatic test_md_mul();
    clear_inputs();
    md_start_e = 1'b1; md_is_div_e = 1'b0; md_use_d = 1'b1;
    #1;
    checks++;
    if ({stall_f, md_busy} !== 2'b10) begin
      errors++; $display("FAIL mul_start_cycle got %b exp 10", {stall_f, md_busy});
    end
    tick();
    md_start_e = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if ({md_busy, md_done, stall_f} !== {1'b1, (i == 4), 1'b1}) begin
        errors++; $display("FAIL mul_busy_c%0d got %b exp %b", i,
                           {md_busy, md_done, stall_f}, {1'b1, (i == 4), 1'b1});
      end
      tick();
    end
    #1;
    checks++;
    if ({md_busy, md_done, stall_f} !== 3'b000) begin
      errors++; $display("FAIL mul_end got %b exp 000", {md_busy, md_done, stall_f});
    end
    tick();
  endtask

  task automatic test_md_repulse();
    clear_inputs();
    md_start_e = 1'b1;
    tick();
    md_start_e = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      md_start_e = (i == 2); md_is_div_e = (i == 2);
      #1;
      checks++;
      if ({md_busy, md_done} !== {1'b1, (i == 4)}) begin
        errors++; $display("FAIL repulse_c%0d got %b exp %b", i, {md_busy, md_done}, {1'b1, (i == 4)});
      end
      tick();
    end
    md_start_e = 1'b0; md_is_div_e = 1'b0;
    #1;
    checks++;
    if (md_busy !== 1'b0) begin
      errors++; $display("FAIL repulse_end got %b exp 0", md_busy);
    end
    tick();
  endtask

  task automatic test_div_reset();
    clear_inputs();
    md_start_e = 1'b1; md_is_div_e = 1'b1;
    tick();
    md_is_div_e = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      md_start_e = (j == 10);
      rst = (j == 20);
      #1;
      checks++;
      if ({md_busy, md_done} !== 2'b10) begin
        errors++; $display("FAIL div_busy_c%0d got %b exp 10", j, {md_busy, md_done});
      end
      tick();
    end
    rst = 1'b0; md_start_e = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++;
      if ({md_busy, md_done} !== 2'b00) begin
        errors++; $display("FAIL div_after_rst_%0d got %b exp 00", j, {md_busy, md_done});
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    md_start_e = 1'b1; md_use_d = 1'b1;
    mem_to_reg_e = 1'b1; write_reg_e = 5'd8; rt_d = 5'd8;
    #1;
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b111) begin
      errors++; $display("FAIL combo_stall got %b exp 111", {stall_f, stall_d, flush_e});
    end
    tick();
    md_start_e = 1'b0; mem_to_reg_e = 1'b0; write_reg_e = '0; md_use_d = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if ({md_busy, md_done, stall_f} !== {1'b1, (i == 4), 1'b0}) begin
        errors++; $display("FAIL combo_busy_c%0d got %b exp %b", i,
                           {md_busy, md_done, stall_f}, {1'b1, (i == 4), 1'b0});
      end
      tick();
    end
    #1;
    checks++;
    if (md_busy !== 1'b0) begin
      errors++; $display("FAIL combo_end got %b exp 0", md_busy);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst = 1'b1;
    tick();
    test_reset();
    test_forward();
    test_lw_stall();
    test_branch();
    test_md_mul();
    test_md_repulse();
    test_div_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
